lsb_queue: RTL and testbench

- Load/store buffer sitting between the Decoder dispatch stage and the memory controller.
- Holds memory instructions in program order and waits for base/data operands, snooping the RS and its own result broadcasts.
- Executes accesses strictly from its head and reports completion to the ROB as lsb_fi/lsb_value/lsb_rob_id.
- Stores and IO-region loads execute only when they are the ROB head; the whole buffer flushes on rob_clear.

---
 rtl/lsb_queue_pkg.sv | 71 +++++++
 rtl/lsb_load_ext.sv | 27 ++
 rtl/lsb_queue.sv | 223 ++++++++++++++++++++++
 tb/tb_lsb_queue.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsb_queue_pkg.sv
`default_nettype none
// ==========================================================================
// lsb_queue_pkg : shared encodings, sizes and helpers for the load/store buffer
// Rev 1.0
// ==========================================================================
package lsb_queue_pkg;

   localparam int          LSB_SIZE_BIT = 3;
   localparam int          ROB_SIZE_BIT = 5;
   localparam int          LSB_SIZE     = 1 << LSB_SIZE_BIT;
   localparam logic [31:0] IO_BASE      = 32'h0003_0000;

   localparam logic [2:0] OP_LB  = 3'd0;
   localparam logic [2:0] OP_LH  = 3'd1;
   localparam logic [2:0] OP_LW  = 3'd2;
   localparam logic [2:0] OP_SW  = 3'd3;
   localparam logic [2:0] OP_LBU = 3'd4;
   localparam logic [2:0] OP_LHU = 3'd5;
   localparam logic [2:0] OP_SB  = 3'd6;
   localparam logic [2:0] OP_SH  = 3'd7;

   localparam logic [1:0] LEN_BYTE = 2'd0;
   localparam logic [1:0] LEN_HALF = 2'd1;
   localparam logic [1:0] LEN_WORD = 2'd2;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_BUSY  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   typedef logic [LSB_SIZE_BIT-1:0] ptr_t;
   typedef logic [LSB_SIZE_BIT:0]   cnt_t;
   typedef logic [ROB_SIZE_BIT-1:0] rob_t;

   typedef struct packed {
      logic        valid;
      logic [2:0]  op;
      rob_t        rob;
      logic [31:0] imm;
      logic [31:0] vj;
      logic [31:0] vk;
      logic        j_rdy;
      logic        k_rdy;
      rob_t        qj;
      rob_t        qk;
   } entry_t;

   function automatic logic is_store(input logic [2:0] op);
      is_store = (op == OP_SW) || (op == OP_SB) || (op == OP_SH);
   endfunction

   function automatic logic [1:0] op_len(input logic [2:0] op);
      case (op)
         OP_LB, OP_LBU, OP_SB: op_len = LEN_BYTE;
         OP_LH, OP_LHU, OP_SH: op_len = LEN_HALF;
         default:              op_len = LEN_WORD;
      endcase
   endfunction

   // Returns {ready, value}: keeps a ready operand, otherwise picks up a matching broadcast.
   function automatic logic [32:0] snoop(
      input logic rdy, input rob_t tag, input logic [31:0] val,
      input logic a_fi, input rob_t a_tag, input logic [31:0] a_val,
      input logic b_fi, input rob_t b_tag, input logic [31:0] b_val);
      if (rdy)                       snoop = {1'b1, val};
      else if (a_fi && a_tag == tag) snoop = {1'b1, a_val};
      else if (b_fi && b_tag == tag) snoop = {1'b1, b_val};
      else                           snoop = {1'b0, val};
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsb_load_ext.sv
`default_nettype none
// ==========================================================================
// lsb_load_ext : sign/zero extension of raw memory data by load opcode
// Rev 1.0
// ==========================================================================
module lsb_load_ext
   import lsb_queue_pkg::*;
(
   input  logic [2:0]  op_i,
   input  logic [31:0] raw_i,
   output logic [31:0] value_o
);

   always_comb begin
      value_o = '0;
      case (op_i)
         OP_LB:   value_o = {{24{raw_i[7]}}, raw_i[7:0]};
         OP_LH:   value_o = {{16{raw_i[15]}}, raw_i[15:0]};
         OP_LW:   value_o = raw_i;
         OP_LBU:  value_o = {24'd0, raw_i[7:0]};
         OP_LHU:  value_o = {16'd0, raw_i[15:0]};
         default: value_o = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/lsb_queue.sv
`default_nettype none
// ==========================================================================
// lsb_queue : in-order load/store buffer between dispatch and memory controller
// Rev 1.0
// ==========================================================================
module lsb_queue
   import lsb_queue_pkg::*;
(
   input  logic                    clk_in,
   input  logic                    rst_n_in,
   input  logic                    rdy_in,
   output logic                    lsb_full,
   input  logic                    lsb_input,
   input  logic [2:0]              lsb_op,
   input  logic [ROB_SIZE_BIT-1:0] lsb_rob_in,
   input  logic [31:0]             lsb_imm,
   input  logic [31:0]             lsb_vj,
   input  logic [31:0]             lsb_vk,
   input  logic                    lsb_qj_rdy,
   input  logic                    lsb_qk_rdy,
   input  logic [ROB_SIZE_BIT-1:0] lsb_qj,
   input  logic [ROB_SIZE_BIT-1:0] lsb_qk,
   input  logic                    rs_fi,
   input  logic [ROB_SIZE_BIT-1:0] rs_rob_id,
   input  logic [31:0]             rs_value,
   input  logic [ROB_SIZE_BIT-1:0] rob_head_id,
   input  logic                    rob_clear,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [1:0]              mem_len,
   output logic [31:0]             mem_addr,
   output logic [31:0]             mem_wdata,
   input  logic                    mem_done,
   input  logic [31:0]             mem_rdata,
   output logic                    lsb_fi,
   output logic [ROB_SIZE_BIT-1:0] lsb_rob_id,
   output logic [31:0]             lsb_value
);

   entry_t      entry_q [LSB_SIZE];
   entry_t      entry_d [LSB_SIZE];
   ptr_t        head_q, head_d, tail_q, tail_d;
   cnt_t        count_q, count_d;
   logic [1:0]  state_q, state_d;

   logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
   logic [1:0]  mem_len_q, mem_len_d;
   logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
   logic        lsb_fi_q, lsb_fi_d;
   rob_t        lsb_rob_id_q, lsb_rob_id_d;
   logic [31:0] lsb_value_q, lsb_value_d;

   logic        head_valid, head_j_rdy, head_k_rdy, head_store, head_needs_commit;
   logic [2:0]  head_op;
   rob_t        head_rob;
   logic [31:0] head_addr, head_vk, ext_value;
   logic        issue, pop, push;

   assign head_valid = entry_q[head_q].valid;
   assign head_j_rdy = entry_q[head_q].j_rdy;
   assign head_k_rdy = entry_q[head_q].k_rdy;
   assign head_op    = entry_q[head_q].op;
   assign head_rob   = entry_q[head_q].rob;
   assign head_vk    = entry_q[head_q].vk;
   assign head_addr  = entry_q[head_q].vj + entry_q[head_q].imm;
   assign head_store = is_store(head_op);

   // Stores and IO loads have side effects, so they wait until they are the ROB head.
   assign head_needs_commit = head_store || (head_addr >= IO_BASE);

   assign issue = rdy_in && !rob_clear && (state_q == ST_IDLE) && head_valid && head_j_rdy
                  && (!head_store || head_k_rdy)
                  && (!head_needs_commit || head_rob == rob_head_id);
   assign pop   = rdy_in && !rob_clear && (state_q == ST_BUSY) && mem_done;
   assign push  = rdy_in && !rob_clear && lsb_input && (count_q != cnt_t'(LSB_SIZE));

   assign lsb_full = (count_q == cnt_t'(LSB_SIZE))
                     || ((count_q == cnt_t'(LSB_SIZE - 1)) && lsb_input && !pop);

   lsb_load_ext u_load_ext (
      .op_i    (head_op),
      .raw_i   (mem_rdata),
      .value_o (ext_value)
   );

   always_comb begin
      for (int i = 0; i < LSB_SIZE; i++) begin
         entry_d[i] = entry_q[i];
         {entry_d[i].j_rdy, entry_d[i].vj} = snoop(entry_q[i].j_rdy, entry_q[i].qj, entry_q[i].vj,
            rs_fi, rs_rob_id, rs_value, lsb_fi_q, lsb_rob_id_q, lsb_value_q);
         {entry_d[i].k_rdy, entry_d[i].vk} = snoop(entry_q[i].k_rdy, entry_q[i].qk, entry_q[i].vk,
            rs_fi, rs_rob_id, rs_value, lsb_fi_q, lsb_rob_id_q, lsb_value_q);
         if (pop && head_q == ptr_t'(i)) entry_d[i].valid = 1'b0;
         if (push && tail_q == ptr_t'(i)) begin
            entry_d[i].valid = 1'b1;
            entry_d[i].op    = lsb_op;
            entry_d[i].rob   = lsb_rob_in;
            entry_d[i].imm   = lsb_imm;
            entry_d[i].qj    = lsb_qj;
            entry_d[i].qk    = lsb_qk;
            {entry_d[i].j_rdy, entry_d[i].vj} = snoop(lsb_qj_rdy, lsb_qj, lsb_vj,
               rs_fi, rs_rob_id, rs_value, lsb_fi_q, lsb_rob_id_q, lsb_value_q);
            {entry_d[i].k_rdy, entry_d[i].vk} = snoop(lsb_qk_rdy, lsb_qk, lsb_vk,
               rs_fi, rs_rob_id, rs_value, lsb_fi_q, lsb_rob_id_q, lsb_value_q);
         end
         if (rob_clear) entry_d[i].valid = 1'b0;
      end
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (rob_clear) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (pop)  head_d = head_q + ptr_t'(1);
         if (push) tail_d = tail_q + ptr_t'(1);
         count_d = count_q + cnt_t'(push) - cnt_t'(pop);
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int i = 0; i < LSB_SIZE; i++) entry_q[i] <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (rdy_in) begin
         for (int i = 0; i < LSB_SIZE; i++) entry_q[i] <= entry_d[i];
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)   state_q <= ST_IDLE;
      else if (rdy_in) state_q <= state_d;
   end

   // A flushed access still owns the bus, so DRAIN waits for its mem_done.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (issue) state_d = ST_BUSY;
         ST_BUSY: begin
            if (mem_done)       state_d = ST_IDLE;
            else if (rob_clear) state_d = ST_DRAIN;
         end
         ST_DRAIN: if (mem_done) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_len_d    = mem_len_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      lsb_fi_d     = 1'b0;
      lsb_rob_id_d = lsb_rob_id_q;
      lsb_value_d  = lsb_value_q;
      case (state_q)
         ST_IDLE: begin
            if (issue) begin
               mem_req_d   = 1'b1;
               mem_we_d    = head_store;
               mem_len_d   = op_len(head_op);
               mem_addr_d  = head_addr;
               mem_wdata_d = head_vk;
            end
         end
         ST_BUSY, ST_DRAIN: begin
            if (mem_done) begin
               mem_req_d = 1'b0;
               if (state_q == ST_BUSY && !rob_clear) begin
                  lsb_fi_d     = 1'b1;
                  lsb_rob_id_d = head_rob;
                  lsb_value_d  = ext_value;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_len_q    <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         lsb_fi_q     <= 1'b0;
         lsb_rob_id_q <= '0;
         lsb_value_q  <= '0;
      end else if (rdy_in) begin
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_len_q    <= mem_len_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         lsb_fi_q     <= lsb_fi_d;
         lsb_rob_id_q <= lsb_rob_id_d;
         lsb_value_q  <= lsb_value_d;
      end
   end

   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_len    = mem_len_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign lsb_fi     = lsb_fi_q;
   assign lsb_rob_id = lsb_rob_id_q;
   assign lsb_value  = lsb_value_q;

endmodule
`default_nettype wire

// File: tb/tb_lsb_queue.sv
`default_nettype none
// ==========================================================================
// tb_lsb_queue : directed and randomized self-checking bench for lsb_queue
// Rev 1.0
// ==========================================================================
module tb_lsb_queue;
   import lsb_queue_pkg::*;

   logic        clk_in = 1'b0;
   logic        rst_n_in, rdy_in, lsb_full, lsb_input;
   logic [2:0]  lsb_op;
   logic [4:0]  lsb_rob_in, lsb_qj, lsb_qk, rs_rob_id, rob_head_id, lsb_rob_id;
   logic [31:0] lsb_imm, lsb_vj, lsb_vk, rs_value, mem_addr, mem_wdata, mem_rdata, lsb_value;
   logic        lsb_qj_rdy, lsb_qk_rdy, rs_fi, rob_clear, mem_req, mem_we, mem_done, lsb_fi;
   logic [1:0]  mem_len;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      logic [4:0]  rob;
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] val;
   } txn_t;
   txn_t model[$];

   always #5 clk_in = ~clk_in;

   lsb_queue dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .lsb_full(lsb_full),
      .lsb_input(lsb_input), .lsb_op(lsb_op), .lsb_rob_in(lsb_rob_in), .lsb_imm(lsb_imm),
      .lsb_vj(lsb_vj), .lsb_vk(lsb_vk), .lsb_qj_rdy(lsb_qj_rdy), .lsb_qk_rdy(lsb_qk_rdy),
      .lsb_qj(lsb_qj), .lsb_qk(lsb_qk), .rs_fi(rs_fi), .rs_rob_id(rs_rob_id),
      .rs_value(rs_value), .rob_head_id(rob_head_id), .rob_clear(rob_clear),
      .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
      .lsb_fi(lsb_fi), .lsb_rob_id(lsb_rob_id), .lsb_value(lsb_value)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_ext(input logic [2:0] op, input logic [31:0] r);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      b = r[7:0];
      h = r[15:0];
      case (op)
         3'd0:    return int'(b);
         3'd1:    return int'(h);
         3'd2:    return r;
         3'd4:    return 32'(r[7:0]);
         3'd5:    return 32'(r[15:0]);
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [1:0] ref_len(input logic [2:0] op);
      if (op == 3'd0 || op == 3'd4 || op == 3'd6) return 2'd0;
      if (op == 3'd1 || op == 3'd5 || op == 3'd7) return 2'd1;
      return 2'd2;
   endfunction

   task automatic dispatch(input logic [2:0] op, input logic [4:0] rob, input logic [31:0] imm,
                           input logic [31:0] vj, input logic [31:0] vk, input logic jr,
                           input logic kr, input logic [4:0] qj, input logic [4:0] qk);
      lsb_input = 1'b1; lsb_op = op; lsb_rob_in = rob; lsb_imm = imm;
      lsb_vj = vj; lsb_vk = vk; lsb_qj_rdy = jr; lsb_qk_rdy = kr; lsb_qj = qj; lsb_qk = qk;
      @(negedge clk_in);
      lsb_input = 1'b0;
   endtask

   task automatic wait_req(input string tag);
      int n = 0;
      while (!mem_req && n < 20) begin
         @(negedge clk_in);
         n++;
      end
      chk(tag, 32'(mem_req), 32'd1);
   endtask

   task automatic complete(input logic [31:0] data);
      mem_done = 1'b1; mem_rdata = data;
      @(negedge clk_in);
      mem_done = 1'b0;
   endtask

   initial begin
      int          lat, sent;
      bit          pending, rdy_prev;
      logic [4:0]  next_rob;
      logic [31:0] vj, imm;
      txn_t        t;

      rst_n_in = 1'b0; rdy_in = 1'b1; lsb_input = 1'b0; lsb_op = '0; lsb_rob_in = '0;
      lsb_imm = '0; lsb_vj = '0; lsb_vk = '0; lsb_qj_rdy = 1'b0; lsb_qk_rdy = 1'b0;
      lsb_qj = '0; lsb_qk = '0; rs_fi = 1'b0; rs_rob_id = '0; rs_value = '0;
      rob_head_id = '0; rob_clear = 1'b0; mem_done = 1'b0; mem_rdata = '0;
      repeat (3) @(negedge clk_in);
      chk("rst_full", 32'(lsb_full), 0);   chk("rst_req", 32'(mem_req), 0);
      chk("rst_we", 32'(mem_we), 0);       chk("rst_fi", 32'(lsb_fi), 0);
      chk("rst_len", 32'(mem_len), 0);     chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);      chk("rst_value", lsb_value, 0);
      chk("rst_robid", 32'(lsb_rob_id), 0);
      rst_n_in = 1'b1;
      @(negedge clk_in);

      // Basic word load
      dispatch(3'd2, 5'd3, 32'd4, 32'h100, 32'd0, 1'b1, 1'b1, 5'd0, 5'd0);
      wait_req("t1_req");
      chk("t1_addr", mem_addr, 32'h104); chk("t1_len", 32'(mem_len), 2); chk("t1_we", 32'(mem_we), 0);
      complete(32'hDEADBEEF);
      chk("t1_fi", 32'(lsb_fi), 1); chk("t1_rob", 32'(lsb_rob_id), 3);
      chk("t1_val", lsb_value, 32'hDEADBEEF); chk("t1_req_low", 32'(mem_req), 0);
      @(negedge clk_in);
      chk("t1_fi_pulse", 32'(lsb_fi), 0);

      // LB then LBU ordering and extension
      dispatch(3'd0, 5'd8, 32'd0, 32'h200, 32'd0, 1'b1, 1'b1, 5'd0, 5'd0);
      dispatch(3'd4, 5'd9, 32'd1, 32'h200, 32'd0, 1'b1, 1'b1, 5'd0, 5'd0);
      wait_req("t2_req1");
      chk("t2_len1", 32'(mem_len), 0);
      complete(32'h00000080);
      chk("t2_rob1", 32'(lsb_rob_id), 8); chk("t2_val1", lsb_value, 32'hFFFFFF80);
      wait_req("t2_req2");
      chk("t2_addr2", mem_addr, 32'h201);
      complete(32'h00000080);
      chk("t2_rob2", 32'(lsb_rob_id), 9); chk("t2_val2", lsb_value, 32'h00000080);

      // Store waiting on RS data and on ROB head
      dispatch(3'd3, 5'd5, 32'd8, 32'h300, 32'hBAD, 1'b1, 1'b0, 5'd0, 5'd2);
      rs_fi = 1'b1; rs_rob_id = 5'd2; rs_value = 32'h55;
      @(negedge clk_in);
      rs_fi = 1'b0;
      repeat (4) @(negedge clk_in);
      chk("t3_noreq", 32'(mem_req), 0);
      rob_head_id = 5'd5;
      wait_req("t3_req");
      chk("t3_we", 32'(mem_we), 1); chk("t3_wdata", mem_wdata, 32'h55); chk("t3_addr", mem_addr, 32'h308);
      complete(32'hFFFFFFFF);
      chk("t3_fi", 32'(lsb_fi), 1); chk("t3_rob", 32'(lsb_rob_id), 5); chk("t3_val", lsb_value, 0);
      rob_head_id = 5'd6;

      // IO load waits for head; just-below-IO load is speculative
      dispatch(3'd2, 5'd7, 32'd4, 32'h30000, 32'd0, 1'b1, 1'b1, 5'd0, 5'd0);
      repeat (4) @(negedge clk_in);
      chk("t4_noreq", 32'(mem_req), 0);
      rob_head_id = 5'd7;
      wait_req("t4_req");
      chk("t4_addr", mem_addr, 32'h30004);
      complete(32'h12345678);
      chk("t4_rob", 32'(lsb_rob_id), 7); chk("t4_val", lsb_value, 32'h12345678);
      rob_head_id = 5'd0;
      dispatch(3'd2, 5'd10, 32'd4, 32'h2FFF8, 32'd0, 1'b1, 1'b1, 5'd0, 5'd0);
      wait_req("t4b_req");
      chk("t4b_addr", mem_addr, 32'h2FFFC);
      complete(32'hCAFE0001);
      chk("t4b_rob", 32'(lsb_rob_id), 10);

      // Flush with a load in flight
      dispatch(3'd2, 5'd11, 32'd0, 32'h400, 32'd0, 1'b1, 1'b1, 5'd0, 5'd0);
      dispatch(3'd2, 5'd12, 32'd0, 32'h404, 32'd0, 1'b1, 1'b1, 5'd0, 5'd0);
      wait_req("t5_req");
      rob_clear = 1'b1;
      lsb_input = 1'b1; lsb_op = 3'd2; lsb_rob_in = 5'd14; lsb_vj = 32'h600; lsb_imm = 0;
      @(negedge clk_in);
      rob_clear = 1'b0; lsb_input = 1'b0;
      chk("t5_req_held", 32'(mem_req), 1);
      repeat (2) @(negedge clk_in);
      chk("t5_req_held2", 32'(mem_req), 1);
      complete(32'h11111111);
      chk("t5_no_fi", 32'(lsb_fi), 0); chk("t5_req_drop", 32'(mem_req), 0);
      chk("t5_full", 32'(lsb_full), 0);
      @(negedge clk_in);
      chk("t5_no_fi2", 32'(lsb_fi), 0); chk("t5_no_req", 32'(mem_req), 0);
      dispatch(3'd2, 5'd13, 32'd0, 32'h500, 32'd0, 1'b1, 1'b1, 5'd0, 5'd0);
      wait_req("t5_new_req");
      chk("t5_new_addr", mem_addr, 32'h500);
      complete(32'h0000ABCD);
      chk("t5_new_rob", 32'(lsb_rob_id), 13);

      // Fill all entries with operands pending, then drain across the wrap
      for (int i = 0; i < 7; i++)
         dispatch(3'd2, 5'(16 + i), 32'(4 * i), 32'd0, 32'd0, 1'b0, 1'b1, 5'd30, 5'd0);
      #1 chk("t6_full_idle", 32'(lsb_full), 0);
      lsb_input = 1'b1; lsb_op = 3'd2; lsb_rob_in = 5'd23; lsb_imm = 32'd28; lsb_qj_rdy = 1'b0; lsb_qj = 5'd30;
      #1 chk("t6_full_c7", 32'(lsb_full), 1);
      @(negedge clk_in);
      lsb_input = 1'b0;
      #1 chk("t6_full_c8", 32'(lsb_full), 1);
      rs_fi = 1'b1; rs_rob_id = 5'd30; rs_value = 32'h700;
      @(negedge clk_in);
      rs_fi = 1'b0;
      for (int i = 0; i < 8; i++) begin
         wait_req($sformatf("t6_req%0d", i));
         chk($sformatf("t6_addr%0d", i), mem_addr, 32'h700 + 32'(4 * i));
         complete(32'h1111 * 32'(i + 1));
         chk($sformatf("t6_rob%0d", i), 32'(lsb_rob_id), 32'(16 + i));
         chk($sformatf("t6_val%0d", i), lsb_value, 32'h1111 * 32'(i + 1));
      end
      @(negedge clk_in);

      // Randomized traffic against the in-order queue model
      pending = 1'b0; rdy_prev = 1'b1; sent = 0; lat = 0; next_rob = 5'd0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (sent >= 60 && model.size() == 0 && !pending) break;
         if (rdy_prev) begin
            if (lsb_fi) begin
               if (model.size() == 0) chk("rnd_spurious_fi", 32'(lsb_fi), 0);
               else begin
                  chk("rnd_rob", 32'(lsb_rob_id), 32'(model[0].rob));
                  chk("rnd_val", lsb_value, model[0].val);
                  void'(model.pop_front());
               end
            end
            if (mem_req && !pending) begin
               if (model.size() == 0) chk("rnd_spurious_req", 32'(mem_req), 0);
               else begin
                  chk("rnd_addr", mem_addr, model[0].addr);
                  chk("rnd_we", 32'(mem_we), 32'(model[0].op == 3'd3 || model[0].op >= 3'd6));
                  chk("rnd_len", 32'(mem_len), 32'(ref_len(model[0].op)));
                  if (mem_we) chk("rnd_wdata", mem_wdata, model[0].wdata);
               end
               pending = 1'b1;
               lat = $urandom_range(0, 3);
            end
         end
         mem_done = 1'b0; lsb_input = 1'b0;
         rdy_in = ($urandom_range(0, 7) != 0);
         if (rdy_in) begin
            if (pending) begin
               if (lat == 0) begin
                  mem_done = 1'b1; mem_rdata = $urandom;
                  model[0].val = ref_ext(model[0].op, mem_rdata);
                  pending = 1'b0;
               end else lat--;
            end
            if (sent < 60 && model.size() < 7 && $urandom_range(0, 1) == 1) begin
               vj  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 32'h2FFFF)) : $urandom;
               imm = 32'($urandom_range(0, 255)) - 32'd128;
               t.op = 3'($urandom_range(0, 7)); t.rob = next_rob; t.addr = vj + imm;
               t.wdata = $urandom; t.val = 32'd0;
               lsb_input = 1'b1; lsb_op = t.op; lsb_rob_in = t.rob; lsb_imm = imm; lsb_vj = vj;
               lsb_vk = t.wdata; lsb_qj_rdy = 1'b1; lsb_qk_rdy = 1'b1;
               model.push_back(t);
               next_rob = next_rob + 5'd1;
               sent++;
            end
         end
         rob_head_id = (model.size() > 0) ? model[0].rob : next_rob;
         rdy_prev = rdy_in;
         @(negedge clk_in);
      end
      chk("rnd_drained", 32'(model.size()), 0);
      chk("rnd_sent", 32'(sent), 60);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
